fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipeline. Owns the program counter, drives the instruction-bus request/response handshake, and registers each fetched word with its PC into the fetch/decode pipeline register. The decoder consumes that register directly. Handles branch/jump redirects from execute, including squashing an in-flight fetch. Provides a one-entry skid buffer so back-pressure from decode never drops a returned instruction.

## Interface
Parameters:
- PC_RESET, 64'h8000_0000, PC fetched first after reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- ireq_valid  out  1  fetch request valid
- ireq_addr  out  64  fetch address; stable while ireq_valid until iresp_data_ok
- iresp_data_ok  in  1  response valid this cycle; may assert in the request's first cycle
- iresp_data  in  32  instruction word, valid with iresp_data_ok
- redirect_valid  in  1  taken branch/jump from execute; flushes fetch
- redirect_pc  in  64  redirect target; bits [1:0] ignored (treated as 0)
- stall  in  1  decode cannot accept; hold d_* outputs
- d_valid  out  1  fetch/decode register holds a valid instruction
- d_pc  out  64  PC of d_raw_instr
- d_raw_instr  out  32  instruction word to decoder

## Operation
- Registers: pc (next fetch PC), req_addr (address of outstanding request), skid_valid/skid_pc/skid_instr, d_valid/d_pc/d_raw_instr, state.
- Reset values: pc=PC_RESET, req_addr=PC_RESET, state=REQ, d_valid=0, d_pc=0, d_raw_instr=0, skid_valid=0. ireq_valid=0 while reset is high.
- ireq_valid = (state==REQ || state==DISCARD); ireq_addr = req_addr.
- Output slot "free" = !d_valid || !stall.
- REQ, no redirect, data_ok:
  - If free: load d_* <= {1, req_addr, iresp_data}; pc and req_addr <= req_addr+4. Stay REQ.
  - Else: load skid <= {1, req_addr, iresp_data}; pc <= req_addr+4. Go to HOLD.
- REQ, no data_ok: hold req_addr. If free, clear d_valid.
- HOLD: ireq_valid=0. When !stall, move skid into d_*, clear skid_valid, set req_addr <= pc, and go to REQ.
- DISCARD: request to the old req_addr is still outstanding. On data_ok, drop the data, set req_addr <= pc, and go to REQ.
- Redirect has highest priority over stall and data_ok:
  - Clears d_valid and skid_valid.
  - Sets pc <= {redirect_pc[63:2],2'b0}.
  - REQ without data_ok -> DISCARD. req_addr unchanged so the address stays stable.
  - REQ with data_ok -> data dropped; req_addr <= redirect target; stay REQ.
  - HOLD -> REQ with req_addr <= target.
  - DISCARD -> stays DISCARD with pc updated; last redirect wins.
- When stall=1 and there is no redirect, d_* hold their values.
- pc+4 wraps modulo 2^64.

## Timing
- Request issued combinationally from state. data_ok in cycle N gives d_valid=1 after edge N, and the next request (addr+4) is presented in cycle N+1.
- With data_ok asserted every cycle and no stall, throughput is one instruction per cycle.
- Redirect in cycle N: d_valid=0 after edge N. The first target fetch is presented in cycle N+1 (from REQ/HOLD) or in the cycle after the discarded data_ok (from DISCARD).
- Reset asserted mid-operation: all outputs return to reset values immediately. Any in-flight response is ignored, and fetching restarts at PC_RESET after deassertion.

## Test plan
- Reset release, data_ok every cycle, no stall -> ireq_addr 0x8000_0000, 0x8000_0004, 0x8000_0008…; d_pc follows one cycle later with d_valid=1 continuously.
- data_ok delayed 3 cycles -> ireq_addr held at 0x8000_0000 for 4 cycles; d_valid=0 until after data_ok.
- Stall asserted with d_valid=1 when data_ok arrives -> state HOLD, ireq_valid=0, d_* unchanged. Stall released -> d_raw_instr = skid word, d_pc=0x8000_0004, and the request for 0x8000_0008 issues next cycle.
- redirect_pc=0x8000_0102 while a request is outstanding (no data_ok) -> d_valid=0, ireq_addr stays at the old address. On the later data_ok the data is dropped, then ireq_addr=0x8000_0100.
- Redirect and data_ok in the same cycle with stall=1 -> data dropped, d_valid=0, next ireq_addr=target.
- Async reset pulse between clock edges during HOLD -> d_valid=0 and skid cleared immediately; the first request after release is 0x8000_0000.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, ibus handshake, redirect squash,
// one-entry skid and the fetch/decode register.
module fetch_stage #(
  parameter logic [63:0] PC_RESET = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        d_valid,
  output logic [63:0] d_pc,
  output logic [31:0] d_raw_instr
);

  typedef enum logic [1:0] {
    REQ,
    HOLD,
    DISCARD
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic [63:0] req_addr;
  logic        skid_valid;
  logic [63:0] skid_pc;
  logic [31:0] skid_instr;

  logic        free;
  logic [63:0] tgt;
  logic [63:0] seq_pc;

  assign free   = !d_valid || !stall;
  assign tgt    = {redirect_pc[63:2], 2'b00};
  assign seq_pc = req_addr + 64'd4;

  assign ireq_valid = !reset &&
                      (state == REQ || state == DISCARD);
  assign ireq_addr  = req_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= REQ;
      pc          <= PC_RESET;
      req_addr    <= PC_RESET;
      skid_valid  <= 1'b0;
      skid_pc     <= '0;
      skid_instr  <= '0;
      d_valid     <= 1'b0;
      d_pc        <= '0;
      d_raw_instr <= '0;
    end else if (redirect_valid) begin
      d_valid    <= 1'b0;
      skid_valid <= 1'b0;
      pc         <= tgt;
      unique case (state)
        REQ: begin
          // keep old address on the bus until it completes
          if (iresp_data_ok) req_addr <= tgt;
          else state <= DISCARD;
        end
        HOLD: begin
          req_addr <= tgt;
          state    <= REQ;
        end
        default: state <= DISCARD;
      endcase
    end else begin
      unique case (state)
        REQ: begin
          if (iresp_data_ok) begin
            pc <= seq_pc;
            if (free) begin
              d_valid     <= 1'b1;
              d_pc        <= req_addr;
              d_raw_instr <= iresp_data;
              req_addr    <= seq_pc;
            end else begin
              skid_valid <= 1'b1;
              skid_pc    <= req_addr;
              skid_instr <= iresp_data;
              state      <= HOLD;
            end
          end else if (free) begin
            d_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            d_valid     <= skid_valid;
            d_pc        <= skid_pc;
            d_raw_instr <= skid_instr;
            skid_valid  <= 1'b0;
            req_addr    <= pc;
            state       <= REQ;
          end
        end
        default: begin
          if (iresp_data_ok) begin
            req_addr <= pc;
            state    <= REQ;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Random + directed bench for fetch_stage against a
// queue-based model of the fetch buffer.
module tb_fetch_stage;

  localparam logic [63:0] PCR = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        d_valid;
  logic [63:0] d_pc;
  logic [31:0] d_raw_instr;

  fetch_stage #(.PC_RESET(PCR)) dut (
    .clk(clk),
    .reset(rst),
    .ireq_valid(ireq_valid),
    .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok),
    .iresp_data(iresp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .stall(stall),
    .d_valid(d_valid),
    .d_pc(d_pc),
    .d_raw_instr(d_raw_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  // q[0] is what decode sees; a second entry means fetch is blocked
  ent_t        q[$];
  logic [63:0] m_pc;
  logic [63:0] m_req;
  bit          m_drop;

  int total = 0;
  int bad = 0;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    q.delete();
    m_pc   = PCR;
    m_req  = PCR;
    m_drop = 0;
  endfunction

  function automatic void m_step(bit ok, logic [31:0] dat,
                                 bit rd, logic [63:0] tgt,
                                 bit st);
    bit          full;
    bit          take;
    logic [63:0] t;
    full = (q.size() == 2);
    take = (q.size() > 0) && !st;
    t    = {tgt[63:2], 2'b00};
    if (rd) begin
      q.delete();
      m_pc = t;
      if (full) m_req = t;
      else if (!m_drop) begin
        if (ok) m_req = t;
        else m_drop = 1;
      end
    end else if (full) begin
      if (take) begin
        void'(q.pop_front());
        m_req = m_pc;
      end
    end else if (m_drop) begin
      if (ok) begin
        m_drop = 0;
        m_req  = m_pc;
      end
    end else begin
      if (take) void'(q.pop_front());
      if (ok) begin
        q.push_back('{m_req, dat});
        m_pc = m_req + 64'd4;
        if (q.size() == 1) m_req = m_req + 64'd4;
      end
    end
  endfunction

  task automatic compare();
    check("ireq_valid", {63'd0, ireq_valid},
          {63'd0, q.size() < 2});
    if (q.size() < 2) check("ireq_addr", ireq_addr, m_req);
    check("d_valid", {63'd0, d_valid}, {63'd0, q.size() > 0});
    if (q.size() > 0) begin
      check("d_pc", d_pc, q[0].pc);
      check("d_instr", {32'd0, d_raw_instr}, {32'd0, q[0].ins});
    end
  endtask

  // called at posedge+1; drives one cycle, then checks
  task automatic cyc(bit ok, bit rd, logic [63:0] tgt, bit st);
    iresp_data_ok  = ok && (q.size() < 2);
    iresp_data     = $urandom;
    redirect_valid = rd;
    redirect_pc    = tgt;
    stall          = st;
    @(posedge clk);
    m_step(iresp_data_ok, iresp_data, rd, tgt, st);
    #1 compare();
  endtask

  task automatic idle_inputs();
    iresp_data_ok  = 0;
    iresp_data     = '0;
    redirect_valid = 0;
    redirect_pc    = '0;
    stall          = 0;
  endtask

  task automatic reset_release();
    @(negedge clk);
    idle_inputs();
    rst = 0;
    @(posedge clk);
    #1 compare();
    check("first_addr", ireq_addr, PCR);
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    m_reset();
    #2;
    check("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    check("rst_d_valid", {63'd0, d_valid}, 64'd0);
    check("rst_d_pc", d_pc, 64'd0);
    check("rst_d_instr", {32'd0, d_raw_instr}, 64'd0);
    reset_release();

    // streaming, one per cycle
    repeat (5) cyc(1, 0, '0, 0);
    check("stream_addr", ireq_addr, PCR + 64'd20);

    // response delayed three cycles
    repeat (3) cyc(0, 0, '0, 0);
    cyc(1, 0, '0, 0);

    // stall with a full output register
    cyc(1, 0, '0, 1);
    cyc(0, 0, '0, 1);
    check("hold_no_req", {63'd0, ireq_valid}, 64'd0);
    cyc(0, 0, '0, 0);
    cyc(1, 0, '0, 0);

    // redirect with a request outstanding
    cyc(0, 1, PCR + 64'h102, 0);
    cyc(0, 0, '0, 0);
    cyc(1, 0, '0, 0);
    check("redir_addr", ireq_addr, PCR + 64'h100);

    // redirect + data_ok + stall together
    cyc(1, 0, '0, 0);
    cyc(1, 1, PCR + 64'h200, 1);
    check("redir_ok_addr", ireq_addr, PCR + 64'h200);
    check("redir_ok_dv", {63'd0, d_valid}, 64'd0);

    // async reset pulse during HOLD
    cyc(1, 0, '0, 0);
    cyc(1, 0, '0, 1);
    #2;
    iresp_data_ok = 1;
    rst = 1;
    #1;
    check("async_d_valid", {63'd0, d_valid}, 64'd0);
    check("async_ireq", {63'd0, ireq_valid}, 64'd0);
    check("async_skid", {63'd0, dut.skid_valid}, 64'd0);
    m_reset();
    @(posedge clk);
    reset_release();

    // PC wrap at the top of the address space
    cyc(1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    cyc(1, 0, '0, 0);
    check("wrap_dpc", d_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_addr", ireq_addr, 64'd0);

    repeat (4000) begin
      cyc(($urandom % 3) != 0, ($urandom % 10) == 0,
          {$urandom, $urandom}, ($urandom % 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
